// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the stack controller
package stack_pkg;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_POP_WB,
    ST_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_SP = 2'd3;

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - PUSH/POP sequencer between the register file and data memory
module stack_controller
  import stack_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] STACK_BASE  = 16'hFFFF,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [1:0]       req_reg,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [1:0]       rf_read_reg,
  input  logic [WIDTH-1:0] rf_read_data,
  input  logic [WIDTH-1:0] sp_value,
  output logic             rf_write_enable,
  output logic [1:0]       rf_write_reg,
  output logic [WIDTH-1:0] rf_write_data,
  output logic             sp_dec,
  output logic             sp_inc,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       reg_q, reg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ill_q, ill_d;

  assign req_ready   = (state_q == ST_IDLE) && !reset;
  assign rf_read_reg = reg_q;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    data_d  = data_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          reg_d = req_reg;
          if (req_op == OP_PUSH) begin
            state_d = ST_FETCH;
          end else if (req_reg == REG_SP) begin
            // Illegal POP SP reports through DONE so err lands one cycle after accept
            ill_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_POP_RD;
          end
        end
      end
      ST_FETCH: begin
        data_d  = rf_read_data;
        state_d = ST_PUSH_WR;
      end
      ST_PUSH_WR: state_d = (sp_value == STACK_LIMIT) ? ST_IDLE : ST_DONE;
      ST_POP_RD:  state_d = (sp_value == STACK_BASE) ? ST_IDLE : ST_POP_WB;
      ST_POP_WB:  state_d = ST_DONE;
      ST_DONE: begin
        ill_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes depend only on state, latches and RF/memory inputs; reset masks them
  always_comb begin
    done            = 1'b0;
    err             = 1'b0;
    err_code        = ERR_NONE;
    rf_write_enable = 1'b0;
    rf_write_reg    = 2'd0;
    rf_write_data   = '0;
    sp_dec          = 1'b0;
    sp_inc          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_we          = 1'b0;
    mem_re          = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_PUSH_WR: begin
          if (sp_value == STACK_LIMIT) begin
            err      = 1'b1;
            err_code = ERR_OVF;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = sp_value - ONE;
            mem_wdata = data_q;
            sp_dec    = 1'b1;
          end
        end
        ST_POP_RD: begin
          if (sp_value == STACK_BASE) begin
            err      = 1'b1;
            err_code = ERR_UNF;
          end else begin
            mem_re   = 1'b1;
            mem_addr = sp_value;
          end
        end
        ST_POP_WB: begin
          if (reg_q != REG_SP) begin
            rf_write_enable = 1'b1;
            rf_write_reg    = reg_q;
            rf_write_data   = mem_rdata;
            sp_inc          = 1'b1;
          end
        end
        ST_DONE: begin
          if (ill_q) begin
            err      = 1'b1;
            err_code = ERR_ILL;
          end else begin
            done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      reg_q   <= REG_R0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - directed table-driven bench for stack_controller
module tb_stack_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [1:0]  req_reg;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  rf_read_reg;
  logic [15:0] rf_read_data;
  logic [15:0] sp_value;
  logic        rf_write_enable;
  logic [1:0]  rf_write_reg;
  logic [15:0] rf_write_data;
  logic        sp_dec;
  logic        sp_inc;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  stack_controller dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_reg        (req_reg),
    .done           (done),
    .err            (err),
    .err_code       (err_code),
    .rf_read_reg    (rf_read_reg),
    .rf_read_data   (rf_read_data),
    .sp_value       (sp_value),
    .rf_write_enable(rf_write_enable),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .sp_dec         (sp_dec),
    .sp_inc         (sp_inc),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata)
  );

  // Register file model: fixed R0..R2, SP mirrors sp_value
  always_comb begin
    case (rf_read_reg)
      2'd0:    rf_read_data = 16'h0A0A;
      2'd1:    rf_read_data = 16'h1234;
      2'd2:    rf_read_data = 16'h5678;
      default: rf_read_data = sp_value;
    endcase
  end

  // {ready, done, err, err_code[1:0], we, re, dec, inc, wen}
  wire [9:0] strb = {req_ready, done, err, err_code, mem_we, mem_re, sp_dec, sp_inc, rf_write_enable};

  typedef struct {
    logic        op;
    logic [1:0]  rg;
    logic [15:0] sp;
    logic [15:0] mrd;
    logic [1:0]  code;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Walks cycles T+1.. after an accept at edge T, checking the expected timeline
  task automatic check_cycles(input vec_t v, input string tag);
    int last;
    logic [9:0] e;
    last = (v.code == 2'd1) ? 2 : ((v.code != 2'd0) ? 1 : 3);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      e = '0;
      e[9] = (k == last + 1);
      if (v.code != 2'd0) begin
        if (k == last) begin
          e[7]   = 1'b1;
          e[6:5] = v.code;
        end
      end else if (v.op == 1'b0) begin
        if (k == 2) begin e[4] = 1'b1; e[2] = 1'b1; end
        if (k == 3) e[8] = 1'b1;
      end else begin
        if (k == 1) e[3] = 1'b1;
        if (k == 2) begin e[1] = 1'b1; e[0] = 1'b1; end
        if (k == 3) e[8] = 1'b1;
      end
      chk($sformatf("%s c%0d strobes", tag, k), 32'(strb), 32'(e));
      if (e[4]) begin
        chk($sformatf("%s c%0d mem_addr", tag, k), 32'(mem_addr), 32'(v.addr));
        chk($sformatf("%s c%0d mem_wdata", tag, k), 32'(mem_wdata), 32'(v.data));
      end
      if (e[3]) chk($sformatf("%s c%0d mem_addr", tag, k), 32'(mem_addr), 32'(v.addr));
      if (e[0]) begin
        chk($sformatf("%s c%0d rf_write_reg", tag, k), 32'(rf_write_reg), 32'(v.rg));
        chk($sformatf("%s c%0d rf_write_data", tag, k), 32'(rf_write_data), 32'(v.data));
      end
    end
  endtask

  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    sp_value  = v.sp;
    mem_rdata = v.mrd;
    req_op    = v.op;
    req_reg   = v.rg;
    req_valid = 1'b1;
    #1;
    chk($sformatf("%s ready before accept", tag), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    //           op    reg   sp        mrd       code  addr      data
    vecs[0] = '{1'b0, 2'd1, 16'hFFFF, 16'h0000, 2'd0, 16'hFFFE, 16'h1234};
    vecs[1] = '{1'b1, 2'd2, 16'hFFFE, 16'hBEEF, 2'd0, 16'hFFFE, 16'hBEEF};
    vecs[2] = '{1'b0, 2'd0, 16'hFF00, 16'h0000, 2'd1, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 2'd2, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 2'd3, 16'hFFF8, 16'h0000, 2'd3, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 2'd3, 16'hFFF0, 16'h0000, 2'd0, 16'hFFEF, 16'hFFF0};
    vecs[6] = '{1'b0, 2'd2, 16'h0000, 16'h0000, 2'd0, 16'hFFFF, 16'h5678};
    vecs[7] = '{1'b1, 2'd1, 16'hFF00, 16'h1111, 2'd0, 16'hFF00, 16'h1111};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_reg   = 2'd0;
    sp_value  = 16'hFFFF;
    mem_rdata = 16'h0000;

    repeat (2) begin
      @(negedge clk);
      chk("reset strobes", 32'(strb), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset idle", 32'(strb), 32'h200);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], $sformatf("v%0d", i));
      check_cycles(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while in PUSH_WR, with a new request held pending
    issue(vecs[0], "rst");
    @(negedge clk);
    chk("rst fetch strobes", 32'(strb), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_op    = 1'b0;
    req_reg   = 2'd0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst in push_wr strobes", 32'(strb), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst held strobes", 32'(strb), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst released strobes", 32'(strb), 32'h200);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check_cycles('{1'b0, 2'd0, 16'hFFFF, 16'h0000, 2'd0, 16'hFFFE, 16'h0A0A}, "after-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
